taillight_sequencer: RTL
========================

// Module: taillight_sequencer
// PURPOSE
//  Parametrised taillight controller with an internal sequencer and dimmer.
//  Drives a row of N_LAMPS per side with sequential turn, hazard, brake and
//  PWM-dimmed running lights. Has its own step timer, so turn timing is set by
//  STEP_CYCLES. Has its own PWM generator, so no external dimmer clock is used.
//  Sits between the driver-switch synchronisers and the lamp drivers.
// PARAMETERS
//  N_LAMPS     3  lamps per side (>=1); lights_o is 2*N_LAMPS wide
//  STEP_CYCLES 4  clk cycles per sequencer step (>=1)
//  PWM_PERIOD  8  PWM period in clk cycles (>=2)
//  PWM_DUTY    2  cycles lit per PWM period for running lights (0..PWM_PERIOD)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  left_i       in   1          left turn request (synchronous to clk)
//  right_i      in   1          right turn request
//  hazard_i     in   1          hazard request
//  brake_i      in   1          brake pedal
//  runlights_i  in   1          running lights enable
//  lights_o     out  2*N_LAMPS  registered lamp drive
//               left=[2N-1:N], innermost=bit N; right=[N-1:0], innermost=bit N-1
// BEHAVIOUR
//  Reset: all of the following clear immediately, regardless of clk:
//   state=IDLE, step k=0, tmr=0, pwm_cnt=0, lights_o=0.
//  Mode decode (every cycle):
//   hazard_i | (left_i & right_i) -> HAZ
//   left_i only -> LEFT; right_i only -> RIGHT; none -> IDLE
//  Step timer:
//   tmr counts 0..STEP_CYCLES-1 while state!=IDLE; tick = (tmr==STEP_CYCLES-1).
//   tmr wraps to 0 on tick. tmr is held at 0 in IDLE.
//  FSM states IDLE, LEFT, RIGHT, HAZ; step k counts 0..N_LAMPS:
//   - Decoded mode != current state: next edge jumps to the new mode's first
//     step (LEFT/RIGHT k=1; HAZ k=1 = all on; IDLE k=0), and tmr clears.
//     This covers mid-sequence changes too; there is no finishing of a sweep.
//   - LEFT/RIGHT on tick: k -> k+1. After k=N_LAMPS, k -> 0 (dark step),
//     then 0 -> 1.
//   - HAZ on tick: k toggles between 1 (all on) and 0 (all off).
//  Base pattern:
//   LEFT/RIGHT: the k innermost lamps of that side lit, other side dark.
//   HAZ: both sides fully lit if k=1, else dark. IDLE: dark.
//  Brake (brake_i=1):
//   - Any side not currently sequencing a turn is forced fully lit.
//   - In LEFT/RIGHT the turning side keeps its base pattern.
//   - In HAZ and IDLE, all 2*N_LAMPS lamps are lit.
//  Runlights:
//   pwm_cnt free-runs 0..PWM_PERIOD-1 (wraps); pwm_on = (pwm_cnt < PWM_DUTY).
//   If runlights_i=1, every lamp that would be off is driven with pwm_on.
//   Lit lamps stay 1.
//  Latency:
//   lights_o(t+1) = f(state(t), k(t), brake_i(t), runlights_i(t), pwm_cnt(t)).
//   A turn request sampled at edge t changes state at t; lamps follow at t+1.
//   brake_i and runlights_i reach lights_o one edge after sampling.
//  Edge cases:
//   - STEP_CYCLES=1: tick every cycle.
//   - PWM_DUTY=0: runlights add nothing. PWM_DUTY=PWM_PERIOD: dark lamps fully on.
//   - N_LAMPS=1: LEFT alternates lit/dark.
//   - Reset mid-sequence returns to IDLE with dark lamps.
// TESTING (N_LAMPS=3, STEP_CYCLES=4, PWM 8/2)
//  1 Hold left_i -> lights_o 001000,011000,111000,000000, each held 4 cycles, repeating.
//  2 right_i + brake_i -> 111100,111110,111111,111000 sequence; left half always 111.
//  3 hazard_i -> 111111 for 4 cycles, then 000000 for 4 cycles. left_i&right_i behaves identically.
//  4 left_i held; at step 011000 switch to right_i -> next state RIGHT, lights 000100, timer restarted.
//  5 Idle, runlights_i=1 -> lights_o 111111 for 2 of every 8 cycles, else 000000.
//    Add brake_i -> constant 111111.
//  6 rst pulse mid-hazard, asynchronous to clk -> lights_o=0 immediately.
//    After release with no inputs, stays 000000.

Source files
------------

// File: rtl/taillight_sequencer.sv
// Taillight sequencer: sequential turn, hazard, brake and PWM-dimmed running
// lights for a row of N_LAMPS lamps per side, with built-in step timer and PWM.
module taillight_sequencer #(
  parameter int unsigned N_LAMPS     = 3,
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned PWM_PERIOD  = 8,
  parameter int unsigned PWM_DUTY    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 left_i,
  input  logic                 right_i,
  input  logic                 hazard_i,
  input  logic                 brake_i,
  input  logic                 runlights_i,
  output logic [2*N_LAMPS-1:0] lights_o
);

  localparam int unsigned KW = $clog2(N_LAMPS + 1);
  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned PW = $clog2(PWM_PERIOD);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZ} state_t;

  state_t                state, state_nxt, mode;
  logic [KW-1:0]         k, k_nxt;
  logic [TW-1:0]         tmr, tmr_nxt;
  logic [PW-1:0]         pwm_cnt;
  logic                  tick, pwm_on;
  logic [N_LAMPS-1:0]    side_turn, left_d, right_d;
  logic [2*N_LAMPS-1:0]  lights_nxt;

  // Decode the requested mode from the switch inputs
  always_comb begin
    mode = IDLE;
    if (hazard_i || (left_i && right_i)) mode = HAZ;
    else if (left_i)                     mode = LEFT;
    else if (right_i)                    mode = RIGHT;
  end

  assign tick   = (state != IDLE) && (tmr == TW'(STEP_CYCLES - 1));
  assign pwm_on = 32'(pwm_cnt) < PWM_DUTY;

  // State, step and timer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next state: a mode change restarts at the new mode's first step
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    tmr_nxt   = tmr;
    if (mode != state) begin
      state_nxt = mode;
      k_nxt     = (mode == IDLE) ? '0 : KW'(1);
      tmr_nxt   = '0;
    end else if (state != IDLE) begin
      if (tick) begin
        tmr_nxt = '0;
        case (state)
          HAZ:     k_nxt = (k == KW'(1)) ? '0 : KW'(1);
          default: k_nxt = (k == KW'(N_LAMPS)) ? '0 : k + 1'b1;
        endcase
      end else begin
        tmr_nxt = tmr + 1'b1;
      end
    end
  end

  // Free-running dimmer counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 pwm_cnt <= '0;
    else if (pwm_cnt == PW'(PWM_PERIOD - 1)) pwm_cnt <= '0;
    else                                     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Lamp pattern; side vectors are indexed by distance from the centre
  always_comb begin
    side_turn  = '0;
    left_d     = '0;
    right_d    = '0;
    lights_nxt = '0;
    for (int unsigned i = 0; i < N_LAMPS; i++) side_turn[i] = (i < 32'(k));
    case (state)
      LEFT: begin
        left_d = side_turn;
        if (brake_i) right_d = '1;
      end
      RIGHT: begin
        right_d = side_turn;
        if (brake_i) left_d = '1;
      end
      HAZ: begin
        if (k == KW'(1) || brake_i) begin
          left_d  = '1;
          right_d = '1;
        end
      end
      default: begin
        if (brake_i) begin
          left_d  = '1;
          right_d = '1;
        end
      end
    endcase
    for (int unsigned i = 0; i < N_LAMPS; i++) begin
      lights_nxt[N_LAMPS + i]     = left_d[i]  | (runlights_i & pwm_on);
      lights_nxt[N_LAMPS - 1 - i] = right_d[i] | (runlights_i & pwm_on);
    end
  end

  // Registered lamp drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lights_o <= '0;
    else     lights_o <= lights_nxt;
  end

endmodule
